// File: rtl/riscv_pkg.sv
// Shared types for the RV32I hazard/forwarding controller.
// Holds the operand-mux select codes and the shadow pipeline stage records.
package riscv_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_WB    = 2'b01,
    FWD_EXMEM = 2'b10,
    FWD_LINK  = 2'b11
  } fwd_sel_e;

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic              regwrite;
    logic              memread;
    logic              link;
  } stage_t;

  // ID/EX also carries the source operands so forwarding can be resolved in EX.
  typedef struct packed {
    stage_t            dst;
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic              use_rs1;
    logic              use_rs2;
  } idex_t;

endpackage

// File: rtl/fwd_sel_unit.sv
// Per-operand forwarding priority compare: youngest producer wins, x0 never forwarded.
module fwd_sel_unit
  import riscv_pkg::*;
(
  input  logic              use_i,
  input  logic [REG_AW-1:0] rs_i,
  input  stage_t            exmem_i,
  input  stage_t            memwb_i,
  output logic [1:0]        sel_o
);

  always_comb begin
    sel_o = FWD_RF;
    if (use_i && (rs_i != '0)) begin
      if (exmem_i.regwrite && (exmem_i.rd == rs_i)) begin
        sel_o = exmem_i.link ? FWD_LINK : FWD_EXMEM;
      end else if (memwb_i.regwrite && (memwb_i.rd == rs_i)) begin
        sel_o = FWD_WB;
      end
    end
  end

endmodule

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for the 5-stage RV32I pipeline: shadow stages,
// EX operand-mux selects, load-use stall, redirect flush and saturating perf counters.
module hazard_fwd_ctrl #(
  parameter int CNT_W  = 32,
  parameter int REG_AW = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_use_rs1,
  input  logic              id_use_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_regwrite,
  input  logic              id_memread,
  input  logic              id_link,
  input  logic              ex_redirect,
  output logic [1:0]        fwd_a_sel,
  output logic [1:0]        fwd_b_sel,
  output logic              stall,
  output logic              flush_if_id,
  output logic              flush_id_ex,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);
  import riscv_pkg::*;

  idex_t            idex_q, idex_d;
  stage_t           exmem_q, memwb_q;
  logic             load_use;
  logic [1:0]       sel_a, sel_b;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    load_use = id_valid & idex_q.dst.memread & idex_q.dst.regwrite &
               (idex_q.dst.rd != '0) &
               ((id_use_rs1 & (id_rs1 == idex_q.dst.rd)) |
                (id_use_rs2 & (id_rs2 == idex_q.dst.rd)));
    // A redirect kills the ID instruction, so it has nothing left to wait for.
    stall       = load_use & ~ex_redirect & ~reset;
    flush_if_id = ex_redirect & ~reset;
    flush_id_ex = ex_redirect & ~reset;
  end

  always_comb begin
    idex_d = '0;
    if (id_valid && !load_use && !ex_redirect) begin
      idex_d.dst.rd       = id_rd;
      idex_d.dst.regwrite = id_regwrite;
      idex_d.dst.memread  = id_memread;
      idex_d.dst.link     = id_link;
      idex_d.rs1          = id_rs1;
      idex_d.rs2          = id_rs2;
      idex_d.use_rs1      = id_use_rs1;
      idex_d.use_rs2      = id_use_rs2;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (stall && !(&stall_cnt_q)) stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (ex_redirect && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      idex_q      <= '0;
      exmem_q     <= '0;
      memwb_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      exmem_q     <= idex_q.dst;
      memwb_q     <= exmem_q;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  fwd_sel_unit u_fwd_a (
    .use_i   (idex_q.use_rs1),
    .rs_i    (idex_q.rs1),
    .exmem_i (exmem_q),
    .memwb_i (memwb_q),
    .sel_o   (sel_a)
  );

  fwd_sel_unit u_fwd_b (
    .use_i   (idex_q.use_rs2),
    .rs_i    (idex_q.rs2),
    .exmem_i (exmem_q),
    .memwb_i (memwb_q),
    .sel_o   (sel_b)
  );

  // Selects drop to the register-file path in the same cycle reset is seen.
  assign fwd_a_sel = reset ? 2'b00 : sel_a;
  assign fwd_b_sel = reset ? 2'b00 : sel_b;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Scoreboard bench for hazard_fwd_ctrl: the driver queues hand-computed expectations
// per cycle, a negedge monitor pops and compares the masked fields.
module tb_hazard_fwd_ctrl;
  localparam int CW = 4;

  localparam logic [5:0] M_A   = 6'h01;
  localparam logic [5:0] M_B   = 6'h02;
  localparam logic [5:0] M_ST  = 6'h04;
  localparam logic [5:0] M_FL  = 6'h08;
  localparam logic [5:0] M_SC  = 6'h10;
  localparam logic [5:0] M_FC  = 6'h20;
  localparam logic [5:0] M_FWD = M_A | M_B;
  localparam logic [5:0] M_ALL = 6'h3f;

  logic          clk = 1'b0;
  logic          reset;
  logic          id_valid;
  logic [4:0]    id_rs1, id_rs2, id_rd;
  logic          id_use_rs1, id_use_rs2;
  logic          id_regwrite, id_memread, id_link;
  logic          ex_redirect;
  logic [1:0]    fwd_a_sel, fwd_b_sel;
  logic          stall, flush_if_id, flush_id_ex;
  logic [CW-1:0] stall_cnt, flush_cnt;

  always #5 clk = ~clk;

  hazard_fwd_ctrl #(.CNT_W(CW), .REG_AW(5)) dut (
    .clk         (clk),
    .reset       (reset),
    .id_valid    (id_valid),
    .id_rs1      (id_rs1),
    .id_rs2      (id_rs2),
    .id_use_rs1  (id_use_rs1),
    .id_use_rs2  (id_use_rs2),
    .id_rd       (id_rd),
    .id_regwrite (id_regwrite),
    .id_memread  (id_memread),
    .id_link     (id_link),
    .ex_redirect (ex_redirect),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel),
    .stall       (stall),
    .flush_if_id (flush_if_id),
    .flush_id_ex (flush_id_ex),
    .stall_cnt   (stall_cnt),
    .flush_cnt   (flush_cnt)
  );

  typedef struct packed {
    logic [7:0]    id;
    logic [5:0]    mask;
    logic [1:0]    a;
    logic [1:0]    b;
    logic          st;
    logic          fl;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   passed = 0;

  task automatic check(input string nm, input int id, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s (test %0d) at %0t: got %0h expected %0h", nm, id, $time, act, exp);
  endtask

  // Monitor: the DUT presents a full output bundle every cycle.
  always @(negedge clk) begin
    exp_t e;
    if (q.size() > 0) begin
      e = q.pop_front();
      if (e.mask[0]) check("fwd_a_sel",   e.id, {6'd0, fwd_a_sel}, {6'd0, e.a});
      if (e.mask[1]) check("fwd_b_sel",   e.id, {6'd0, fwd_b_sel}, {6'd0, e.b});
      if (e.mask[2]) check("stall",       e.id, {7'd0, stall},     {7'd0, e.st});
      if (e.mask[3]) begin
        check("flush_if_id", e.id, {7'd0, flush_if_id}, {7'd0, e.fl});
        check("flush_id_ex", e.id, {7'd0, flush_id_ex}, {7'd0, e.fl});
      end
      if (e.mask[4]) check("stall_cnt",   e.id, 8'(stall_cnt), 8'(e.sc));
      if (e.mask[5]) check("flush_cnt",   e.id, 8'(flush_cnt), 8'(e.fc));
    end
  end

  task automatic drv(input logic v, input logic [4:0] rs1, input logic u1,
                     input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                     input logic rw, input logic mr, input logic lk, input logic rdr);
    id_valid    = v;
    id_rs1      = rs1;
    id_use_rs1  = u1;
    id_rs2      = rs2;
    id_use_rs2  = u2;
    id_rd       = rd;
    id_regwrite = rw;
    id_memread  = mr;
    id_link     = lk;
    ex_redirect = rdr;
  endtask

  task automatic nop(input logic rdr);
    drv(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, rdr);
  endtask

  task automatic expect_cyc(input int id, input logic [5:0] m, input logic [1:0] a,
                            input logic [1:0] b, input logic st, input logic fl,
                            input logic [CW-1:0] sc, input logic [CW-1:0] fc);
    exp_t e;
    e.id = 8'(id); e.mask = m; e.a = a; e.b = b; e.st = st; e.fl = fl; e.sc = sc; e.fc = fc;
    q.push_back(e);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    nop(1'b0);
    @(posedge clk);
    #1;
    expect_cyc(0, M_ALL, 2'b00, 2'b00, 1'b0, 1'b0, 4'd0, 4'd0);
    reset = 1'b0;

    // 1: single-cycle EX/MEM forward on rs1
    drv(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0); expect_cyc(1, M_ALL, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0);
    drv(1, 5'd5, 1, 5'd3, 1, 5'd6, 1, 0, 0, 0); expect_cyc(1, M_ALL, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0);
    nop(0);                                      expect_cyc(1, M_ALL, 2'b10, 2'b00, 0, 0, 4'd0, 4'd0);

    // 2: EX/MEM beats MEM/WB when both write the same rd
    drv(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0); expect_cyc(2, M_ALL, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0);
    drv(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0); expect_cyc(2, M_ALL, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0);
    drv(1, 5'd9, 1, 5'd5, 1, 5'd10, 1, 0, 0, 0); expect_cyc(2, M_ALL, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0);
    nop(0);                                      expect_cyc(2, M_ALL, 2'b00, 2'b10, 0, 0, 4'd0, 4'd0);

    // 3: load-use stall, then MEM/WB forward
    drv(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0); expect_cyc(3, M_ALL, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0);
    drv(1, 5'd7, 1, 5'd4, 1, 5'd8, 1, 0, 0, 0); expect_cyc(3, M_ALL, 2'b00, 2'b00, 1, 0, 4'd0, 4'd0);
    drv(1, 5'd7, 1, 5'd4, 1, 5'd8, 1, 0, 0, 0); expect_cyc(3, M_ALL, 2'b00, 2'b00, 0, 0, 4'd1, 4'd0);
    nop(0);                                      expect_cyc(3, M_ALL, 2'b01, 2'b00, 0, 0, 4'd1, 4'd0);

    // 4: JAL link forward, and x0 never forwarded
    drv(1, 5'd0, 0, 5'd0, 0, 5'd1, 1, 0, 1, 0);  expect_cyc(4, M_ALL, 2'b00, 2'b00, 0, 0, 4'd1, 4'd0);
    drv(1, 5'd1, 1, 5'd6, 1, 5'd11, 1, 0, 0, 0); expect_cyc(4, M_ALL, 2'b00, 2'b00, 0, 0, 4'd1, 4'd0);
    drv(1, 5'd3, 1, 5'd3, 1, 5'd0, 1, 0, 0, 0);  expect_cyc(4, M_ALL, 2'b11, 2'b00, 0, 0, 4'd1, 4'd0);
    drv(1, 5'd0, 1, 5'd0, 1, 5'd12, 1, 0, 0, 0); expect_cyc(4, M_ALL, 2'b00, 2'b00, 0, 0, 4'd1, 4'd0);
    nop(0);                                       expect_cyc(4, M_ALL, 2'b00, 2'b00, 0, 0, 4'd1, 4'd0);

    // 5: redirect overrides load-use; rs2-only stall; load to x0 never stalls
    drv(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0);  expect_cyc(5, M_ALL, 2'b00, 2'b00, 0, 0, 4'd1, 4'd0);
    drv(1, 5'd7, 1, 5'd7, 1, 5'd13, 1, 0, 0, 1); expect_cyc(5, M_ALL, 2'b00, 2'b00, 0, 1, 4'd1, 4'd0);
    nop(0);                                       expect_cyc(5, M_ALL, 2'b00, 2'b00, 0, 0, 4'd1, 4'd1);
    drv(1, 5'd2, 1, 5'd0, 0, 5'd9, 1, 1, 0, 0);  expect_cyc(5, M_ALL, 2'b00, 2'b00, 0, 0, 4'd1, 4'd1);
    drv(1, 5'd3, 1, 5'd9, 1, 5'd14, 1, 0, 0, 0); expect_cyc(5, M_ALL, 2'b00, 2'b00, 1, 0, 4'd1, 4'd1);
    nop(0);                                       expect_cyc(5, M_ALL, 2'b00, 2'b00, 0, 0, 4'd2, 4'd1);
    drv(1, 5'd2, 1, 5'd0, 0, 5'd0, 1, 1, 0, 0);  expect_cyc(5, M_ALL, 2'b00, 2'b00, 0, 0, 4'd2, 4'd1);
    drv(1, 5'd0, 1, 5'd0, 1, 5'd15, 1, 0, 0, 0); expect_cyc(5, M_ALL, 2'b00, 2'b00, 0, 0, 4'd2, 4'd1);

    // 6: drive both counters past all-ones
    for (int i = 0; i < 16; i++) begin
      drv(1, 5'd2, 1, 5'd0, 0, 5'd7, 1, 1, 0, 0); expect_cyc(6, M_ST, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0);
      drv(1, 5'd7, 1, 5'd0, 0, 5'd8, 1, 0, 0, 0); expect_cyc(6, M_ST, 2'b00, 2'b00, 1, 0, 4'd0, 4'd0);
    end
    nop(0); expect_cyc(6, M_ALL, 2'b00, 2'b00, 0, 0, 4'd15, 4'd1);
    for (int i = 0; i < 20; i++) begin
      nop(1); expect_cyc(6, M_ST | M_FL, 2'b00, 2'b00, 0, 1, 4'd0, 4'd0);
    end
    nop(0); expect_cyc(6, M_ALL, 2'b00, 2'b00, 0, 0, 4'd15, 4'd15);

    // 7: reset mid-stream while a forward and a redirect are live
    drv(1, 5'd1, 1, 5'd2, 1, 5'd5, 1, 0, 0, 0); expect_cyc(7, M_FWD, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0);
    drv(1, 5'd5, 1, 5'd0, 0, 5'd6, 1, 0, 0, 0); expect_cyc(7, M_FWD, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0);
    reset = 1'b1;
    nop(1); expect_cyc(7, M_ALL, 2'b00, 2'b00, 0, 0, 4'd15, 4'd15);
    reset = 1'b0;
    drv(1, 5'd5, 1, 5'd6, 1, 5'd3, 1, 0, 0, 0); expect_cyc(7, M_ALL, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0);
    nop(0); expect_cyc(7, M_ALL, 2'b00, 2'b00, 0, 0, 4'd0, 4'd0);

    repeat (3) @(posedge clk);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
